// File: rtl/y1_interval_monitor.sv
// y1_interval_monitor: measures rise-to-rise intervals of the sequencer y1
// output, queues them in a first-word-fall-through FIFO drained over a
// valid/ready stream, and keeps pulse and drop statistics.
module y1_interval_monitor #(
    parameter int CNT_W  = 8,
    parameter int DEPTH  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              y1,
    input  logic              clr_ovf,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [CNT_W-1:0]  m_data,
    output logic              ovf,
    output logic [STAT_W-1:0] pulse_cnt,
    output logic [STAT_W-1:0] drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                y1_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [OCC_W-1:0]    occ_q;
    logic                ovf_q;
    logic [STAT_W-1:0]   pulse_cnt_q;
    logic [STAT_W-1:0]   drop_cnt_q;
    logic [CNT_W-1:0]    mem_q [DEPTH];

    logic rise_s;
    logic push_s;
    logic pop_s;
    logic full_s;
    logic accept_s;
    logic drop_s;

    // Handshake and FIFO control decoded from the current registered state.
    always_comb begin
        rise_s   = y1 & ~y1_q;
        push_s   = (state_q == ST_MEAS) & en & rise_s;
        full_s   = (occ_q == OCC_W'(DEPTH));
        if (occ_q != {OCC_W{1'b0}}) begin
            m_valid = 1'b1;
            m_data  = mem_q[rd_ptr_q];
        end else begin
            m_valid = 1'b0;
            m_data  = {CNT_W{1'b0}};
        end
        pop_s    = m_valid & m_ready;
        accept_s = push_s & (~full_s | pop_s);
        drop_s   = push_s & full_s & ~pop_s;
    end

    assign ovf       = ovf_q;
    assign pulse_cnt = pulse_cnt_q;
    assign drop_cnt  = drop_cnt_q;

    // Edge-detect register for y1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1_q <= 1'b0;
        end else begin
            y1_q <= y1;
        end
    end

    // Interval measurement state machine; the count saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en && rise_s) begin
                        state_q <= ST_MEAS;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MEAS: begin
                    if (!en) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= {CNT_W{1'b0}};
                    end else if (rise_s) begin
                        cnt_q   <= CNT_W'(1);
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q   <= cnt_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // FIFO storage; empty slots are masked on the read side so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q] <= cnt_q;
        end
    end

    // FIFO pointers and occupancy; a push into a full FIFO is only taken alongside a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            occ_q    <= {OCC_W{1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (accept_s && !pop_s) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (pop_s && !accept_s) begin
                occ_q <= occ_q - OCC_W'(1);
            end else begin
                occ_q <= occ_q;
            end
        end
    end

    // Statistics: sticky overflow (a drop beats a clear), wrapping pulse count, saturating drop count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q       <= 1'b0;
            pulse_cnt_q <= {STAT_W{1'b0}};
            drop_cnt_q  <= {STAT_W{1'b0}};
        end else begin
            if (drop_s) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
            if (en && rise_s) begin
                pulse_cnt_q <= pulse_cnt_q + STAT_W'(1);
            end
            if (drop_s && (drop_cnt_q != {STAT_W{1'b1}})) begin
                drop_cnt_q <= drop_cnt_q + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_y1_interval_monitor.sv
// Directed bench for y1_interval_monitor: expected intervals go into a
// scoreboard queue as stimulus is driven and are compared when popped.
module tb_y1_interval_monitor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        y1;
    logic        clr_ovf;
    logic        m_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        ovf;
    logic [15:0] pulse_cnt;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pc   = 0;
    int exp_q[$];

    y1_interval_monitor #(.CNT_W(8), .DEPTH(4), .STAT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .y1        (y1),
        .clr_ovf   (clr_ovf),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .ovf       (ovf),
        .pulse_cnt (pulse_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse();
        y1 = 1'b1;
        tick();
        y1 = 1'b0;
        if (en) exp_pc++;
    endtask

    // Scoreboard: every transfer the DUT completes must match the queue head.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_pop: observed data %0d expected no transfer", m_data);
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                assert (m_data === 8'(exp_q[0])) else begin
                    n_fail++;
                    $error("FAIL stream_data: observed %0d expected %0d", m_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; y1 = 1'b0; clr_ovf = 1'b0; m_ready = 1'b1;

        // Reset held while y1 toggles
        repeat (5) begin
            y1 = ~y1;
            tick();
        end
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_pulse", 32'(pulse_cnt), 32'd0);
        y1 = 1'b0;
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_valid", 32'(m_valid), 32'd0);
        chk("post_rst_ovf", 32'(ovf), 32'd0);
        chk("post_rst_pulse", 32'(pulse_cnt), 32'd0);

        // Basic intervals 5 then 7
        pulse();
        chk("basic_arm_valid", 32'(m_valid), 32'd0);
        idle(4);
        exp_q.push_back(5);
        pulse();
        chk("basic_lat_valid", 32'(m_valid), 32'd1);
        chk("basic_lat_data", 32'(m_data), 32'd5);
        idle(6);
        exp_q.push_back(7);
        pulse();
        chk("basic_lat2_valid", 32'(m_valid), 32'd1);
        chk("basic_lat2_data", 32'(m_data), 32'd7);
        idle(2);
        chk("basic_pulse_cnt", 32'(pulse_cnt), 32'd3);
        chk("basic_ovf", 32'(ovf), 32'd0);
        chk("basic_drained", 32'(m_valid), 32'd0);

        // Held level: one rise per high level
        en = 1'b0; tick(); en = 1'b1;
        y1 = 1'b1; idle(4); y1 = 1'b0; exp_pc++;
        idle(3);
        exp_q.push_back(7);
        pulse();
        chk("held_pulse_cnt", 32'(pulse_cnt), 32'(exp_pc));
        idle(2);
        exp_q.push_back(3);
        pulse();
        tick();
        exp_q.push_back(2);
        pulse();
        idle(2);
        chk("held_pulse_cnt2", 32'(pulse_cnt), 32'(exp_pc));
        chk("held_drained", 32'(exp_q.size()), 32'd0);

        // Overflow with a stalled consumer
        en = 1'b0; tick(); en = 1'b1;
        m_ready = 1'b0;
        pulse();
        for (int i = 0; i < 6; i++) begin
            idle(2);
            if (i < 4) exp_q.push_back(3);
            pulse();
        end
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("ovf_valid", 32'(m_valid), 32'd1);
        chk("ovf_head", 32'(m_data), 32'd3);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd2);
        tick();
        m_ready = 1'b1;
        exp_q.push_back(3);
        pulse();
        chk("full_pop_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("full_pop_ovf", 32'(ovf), 32'd0);
        idle(6);
        chk("ovf_drained", 32'(exp_q.size()), 32'd0);
        chk("ovf_drained_valid", 32'(m_valid), 32'd0);

        // Saturation
        en = 1'b0; tick(); en = 1'b1;
        pulse();
        idle(299);
        exp_q.push_back(255);
        pulse();
        chk("sat_data", 32'(m_data), 32'd255);
        idle(2);

        // Enable dropped mid-interval
        idle(5);
        en = 1'b0; idle(3); en = 1'b1; idle(3);
        pulse();
        tick();
        chk("en_rearm_no_push", 32'(m_valid), 32'd0);
        idle(2);
        exp_q.push_back(4);
        pulse();
        chk("en_interval", 32'(m_data), 32'd4);
        idle(2);
        chk("en_pulse_cnt", 32'(pulse_cnt), 32'(exp_pc));

        // Reset during operation with two queued entries
        m_ready = 1'b0;
        tick();
        pulse();
        tick();
        pulse();
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(m_valid), 32'd0);
        chk("async_data", 32'(m_data), 32'd0);
        chk("async_ovf", 32'(ovf), 32'd0);
        chk("async_pulse", 32'(pulse_cnt), 32'd0);
        chk("async_drop", 32'(drop_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        exp_pc = 0;
        pulse();
        chk("rst_arm_valid", 32'(m_valid), 32'd0);
        idle(3);
        chk("rst_arm_valid2", 32'(m_valid), 32'd0);
        chk("rst_arm_pulse", 32'(pulse_cnt), 32'(exp_pc));
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
